// File: rtl/uart_cmd_wrapper.sv
// Knight-side UART endpoint: assembles two received bytes (high first) into a
// 16-bit command and serialises an 8-bit response byte back to the host.
`timescale 1ns/1ps
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {RX_IDLE, RX_RECV}     rx_state_t;
  typedef enum logic {BYTE_HIGH, BYTE_LOW}  byte_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT}     tx_state_t;

  rx_state_t   rx_state;
  byte_state_t byte_state;
  tx_state_t   tx_state;

  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [8:0]    rx_sh;
  logic          rx_done;
  logic          start_det;
  logic [7:0]    cmd_hi;

  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;

  // Synchroniser flops preset to idle-high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign start_det = (rx_state == RX_IDLE) && rx_s3 && !rx_s2;

  // Samples 1..9 shift in; after the stop sample rx_sh[8] is the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (start_det) begin
            rx_cnt   <= CNT_HALF;
            rx_bit   <= '0;
            rx_state <= RX_RECV;
          end
        end
        RX_RECV: begin
          if (rx_cnt == CNT_ONE) begin
            rx_cnt <= CNT_FULL;
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
              if (rx_s2) rx_state <= RX_IDLE;
            end else begin
              rx_sh <= {rx_s2, rx_sh[8:1]};
              if (rx_bit == 4'd9) begin
                rx_done  <= 1'b1;
                rx_state <= RX_IDLE;
              end
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Setting cmd_rdy is written after the clear so a simultaneous set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_state <= BYTE_HIGH;
      cmd_hi     <= '0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      if (clr_cmd_rdy || (start_det && byte_state == BYTE_HIGH))
        cmd_rdy <= 1'b0;
      if (rx_done) begin
        if (!rx_sh[8]) begin
          byte_state <= BYTE_HIGH;
        end else if (byte_state == BYTE_HIGH) begin
          cmd_hi     <= rx_sh[7:0];
          byte_state <= BYTE_LOW;
        end else begin
          cmd        <= {cmd_hi, rx_sh[7:0]};
          cmd_rdy    <= 1'b1;
          byte_state <= BYTE_HIGH;
        end
      end
    end
  end

  // Start bit is driven directly on load; the shifter holds data then stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
      tx_sh    <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_sh    <= {1'b1, resp};
            TX       <= 1'b0;
            tx_done  <= 1'b0;
            tx_cnt   <= CNT_FULL;
            tx_bit   <= '0;
            tx_state <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt == CNT_ONE) begin
            if (tx_bit == 4'd9) begin
              TX       <= 1'b1;
              tx_done  <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              TX     <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[8:1]};
              tx_bit <= tx_bit + 4'd1;
              tx_cnt <= CNT_FULL;
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: a small host UART model drives RX and
// the TX waveform is checked bit by bit against hand-computed values.
`timescale 1ns/1ps
module tb_uart_cmd_wrapper;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tx_done;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rdy_cycle = 0;
  int   second_start = 0;
  logic rdy_prev = 1'b0;
  logic [9:0] tx_exp;

  uart_cmd_wrapper #(.BAUD_DIV(BAUD)) dut (
    .clk(clk),
    .rst(rst),
    .RX(rx),
    .TX(tx),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp(resp),
    .send_resp(send_resp),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Remember the cycle at which cmd_rdy last rose, for latency measurement.
  always @(negedge clk) begin
    if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) rdy_cycle = cyc;
    rdy_prev = cmd_rdy;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host-side UART byte: start, 8 data bits LSB first, then the given stop bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (BAUD) @(posedge clk);
      #1;
    end
  endtask

  task automatic sendCommand(input logic [15:0] c);
    applyStimulus(c[15:8], 1'b1);
    second_start = cyc;
    applyStimulus(c[7:0], 1'b1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseClear();
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    resp = 8'h00;
    tx_exp = 10'b1101001010;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_cmd", cmd, 16'h0000);
    checkOutput("rst_cmd_rdy", cmd_rdy, 0);
    checkOutput("rst_tx_done", tx_done, 0);
    idleCycles(4);

    // Single command, latency and hold-until-clear behaviour
    sendCommand(16'h43F1);
    checkOutput("t1_cmd", cmd, 16'h43F1);
    checkOutput("t1_rdy", cmd_rdy, 1);
    checkOutput("t1_latency", ((rdy_cycle - second_start) >= 150) && ((rdy_cycle - second_start) <= 170), 1);
    idleCycles(20);
    checkOutput("t1_hold", cmd_rdy, 1);
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b1;
    @(negedge clk);
    checkOutput("t1_before_clr_edge", cmd_rdy, 1);
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    @(negedge clk);
    checkOutput("t1_cleared", cmd_rdy, 0);
    idleCycles(2);

    // Back-to-back commands without an explicit clear
    sendCommand(16'h2000);
    checkOutput("t2_cmd_a", cmd, 16'h2000);
    checkOutput("t2_rdy_a", cmd_rdy, 1);
    fork
      applyStimulus(8'h60, 1'b1);
      begin
        repeat (6) @(negedge clk);
        checkOutput("t2_drop_at_start", cmd_rdy, 0);
        checkOutput("t2_cmd_held", cmd, 16'h2000);
      end
    join
    applyStimulus(8'h23, 1'b1);
    checkOutput("t2_cmd_b", cmd, 16'h6023);
    checkOutput("t2_rdy_b", cmd_rdy, 1);

    // Framing error on the low byte, then resync
    pulseClear();
    applyStimulus(8'h40, 1'b1);
    applyStimulus(8'h55, 1'b0);
    rx = 1'b1;
    idleCycles(20);
    checkOutput("t3_no_rdy", cmd_rdy, 0);
    checkOutput("t3_cmd_kept", cmd, 16'h6023);
    sendCommand(16'h4BF1);
    checkOutput("t3_resync_cmd", cmd, 16'h4BF1);
    checkOutput("t3_resync_rdy", cmd_rdy, 1);

    // Short RX glitch is rejected
    pulseClear();
    rx = 1'b0;
    idleCycles(3);
    rx = 1'b1;
    idleCycles(200);
    checkOutput("t4_no_rdy", cmd_rdy, 0);
    checkOutput("t4_cmd_kept", cmd, 16'h4BF1);
    sendCommand(16'h1234);
    checkOutput("t4_next_cmd", cmd, 16'h1234);
    checkOutput("t4_next_rdy", cmd_rdy, 1);

    // Response transmission with an ignored second request mid-frame
    @(posedge clk);
    #1 resp = 8'hA5;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if ((c % 16) == 0 || (c % 16) == 15)
        checkOutput($sformatf("t5_bit%0d_c%0d", c / 16, c), tx, tx_exp[c / 16]);
      if (c == 0) checkOutput("t5_done_low", tx_done, 0);
      if (c == 50) begin
        resp = 8'h0F;
        send_resp = 1'b1;
      end
      if (c == 51) send_resp = 1'b0;
      if (c == 159) checkOutput("t5_done_not_early", tx_done, 0);
    end
    @(negedge clk);
    checkOutput("t5_tx_idle", tx, 1);
    checkOutput("t5_done_set", tx_done, 1);
    idleCycles(20);
    checkOutput("t5_no_restart", tx, 1);

    // Reset mid-RX and mid-TX
    applyStimulus(8'h5A, 1'b1);
    @(posedge clk);
    #1 resp = 8'h00;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
    rx = 1'b0;
    idleCycles(16);
    rx = 1'b1;
    idleCycles(16);
    rx = 1'b0;
    idleCycles(16);
    @(negedge clk);
    checkOutput("t6_tx_busy", tx, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_tx_reset", tx, 1);
    checkOutput("t6_rdy_reset", cmd_rdy, 0);
    checkOutput("t6_cmd_reset", cmd, 16'h0000);
    checkOutput("t6_done_reset", tx_done, 0);
    idleCycles(20);
    checkOutput("t6_tx_stays_idle", tx, 1);
    sendCommand(16'h3CD2);
    checkOutput("t6_cmd_after", cmd, 16'h3CD2);
    checkOutput("t6_rdy_after", cmd_rdy, 1);
    checkOutput("t6_tx_after", tx, 1);
    checkOutput("t6_done_after", tx_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
Knight-side endpoint of the remote command link; the counterpart of the host-side RemoteComm block. It receives two UART bytes (8N1, high byte first) and assembles them into a 16-bit command for cmd_proc. It also serialises the 8-bit response byte (ack/pos) back to the host. Bit-level UART receive and transmit are implemented internally.

Parameters:
BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); must be >= 8.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
RX  input  1  serial in from host, asynchronous, idle high
TX  output  1  serial out to host, idle high
cmd  output  16  assembled command; {byte1, byte2}
cmd_rdy  output  1  level; a complete command is valid on cmd
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
resp  input  8  response byte to transmit
send_resp  input  1  one-cycle strobe; starts transmission of resp
tx_done  output  1  level; last response fully sent

Behaviour:
- Reset (sync, rst=1 at posedge): TX=1, cmd=0, cmd_rdy=0, tx_done=0. RX synchroniser flops preset to 1. Both FSMs go IDLE; byte FSM goes HIGH. Reset mid-frame abandons the frame with no output pulse.
- RX input: 2-flop synchroniser, then a third flop for edge detect. A start is detected on a synchronised 1->0 edge while RX FSM is IDLE.
- RX FSM (IDLE, RECV):
  - Start detect: load baud counter with BAUD_DIV/2 and bit counter with 0.
  - Each counter expiry samples the synchronised RX and reloads BAUD_DIV.
  - Sample 0 = start bit. If it reads 1, the start was a glitch: return to IDLE with no byte.
  - Samples 1-8 = data, LSB first, shifted into a 9-bit shifter.
  - Sample 9 = stop bit. If stop=1, pulse an internal rx_rdy for 1 cycle with the byte. If stop=0 (framing error), discard the byte. Either way, return to IDLE.
- Byte FSM (HIGH, LOW):
  - In HIGH, rx_rdy latches the byte into cmd_hi and moves to LOW.
  - In LOW, rx_rdy updates cmd to {cmd_hi, byte}, sets cmd_rdy on the next clock edge, and returns to HIGH.
  - A framing error in LOW returns to HIGH (resync); cmd is not updated.
- cmd_rdy clear conditions: clr_cmd_rdy=1, or a new start edge detected while in HIGH (next command beginning).
- Simultaneous set and clr_cmd_rdy in the same cycle: set wins.
- cmd holds its value until the next complete command.
- TX FSM (IDLE, XMIT):
  - send_resp in IDLE loads {resp, 1'b0} into a 10-bit shifter with stop bit 1, clears tx_done, and drives TX=0 from the next cycle.
  - Each bit lasts exactly BAUD_DIV cycles, LSB first after the start bit, then the stop bit.
  - After the stop bit completes, go to IDLE, TX=1, set tx_done.
  - send_resp while in XMIT is ignored (no restart, no queueing).
- Frame latencies:
  - TX frame = 10*BAUD_DIV cycles from the TX falling edge to the return to IDLE.
  - cmd_rdy rises BAUD_DIV/2 + 9*BAUD_DIV + 3 cycles (±1) after the second byte's start edge on RX, including the synchroniser delay.
- RX and TX run fully independently: full duplex, simultaneous activity allowed.

Test Plan:
1. Loopback through host model, BAUD_DIV=16, host sends 16'h43F1 -> cmd=16'h43F1, cmd_rdy=1 within 170 cycles of the second byte's start; cmd_rdy stays high until clr_cmd_rdy, then drops the next cycle.
2. Back-to-back commands 16'h2000 then 16'h6023 without clr_cmd_rdy -> cmd_rdy drops at the 16'h60 start edge; cmd ends at 16'h6023 with cmd_rdy=1.
3. Framing error: first byte 8'h40 good, second byte with stop bit forced 0 -> no cmd_rdy; cmd unchanged. A following good 16'h4BF1 decodes correctly (FSM resynced to HIGH).
4. Glitch on RX (low for 3 cycles, BAUD_DIV=16) -> no byte accepted; state unchanged.
5. send_resp with resp=8'hA5 -> TX waveform 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles; tx_done rises at 160 cycles. A second send_resp at cycle 50 is ignored.
6. rst asserted mid-RX byte and mid-TX frame -> TX=1 and cmd_rdy=0 on the next edge. The next full command after release decodes correctly.
